// File: rtl/data_memory_lsu.sv
// RV32 data memory with a valid/ready request port, byte-lane load/store,
// configurable access latency and error responses.
module data_memory_lsu #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WIW  = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [31:0]           mem_q [DEPTH_WORDS];

  logic                  op_wr;
  logic [2:0]            op_f3;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [31:0]           op_wdata;
  logic [WIW-1:0]        widx;
  logic [IDXW-1:0]       idx;
  logic [1:0]            lane;
  logic                  op_err;
  logic [31:0]           word_rd, load_data, wd_sh;
  logic [7:0]            byte_rd;
  logic [15:0]           half_rd;
  logic [3:0]            be;
  logic                  commit;

  // With LATENCY=0 the accept edge is also the commit edge, so decode works
  // on the live request while idle and on the latched copy otherwise.
  always_comb begin
    op_wr    = wr_q;
    op_f3    = f3_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state_q == IDLE) begin
      op_wr    = req_write;
      op_f3    = req_funct3;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end
  end

  always_comb begin
    widx    = op_addr[ADDR_WIDTH-1:2];
    idx     = widx[IDXW-1:0];
    lane    = op_addr[1:0];
    op_err  = (op_wr ? (op_f3 > 3'd2)
                     : !(op_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            || (op_f3[1:0] == 2'b01 && lane[0])
            || (op_f3[1:0] == 2'b10 && lane != 2'b00)
            || (widx >= WIW'(DEPTH_WORDS));
    word_rd = mem_q[idx];
    byte_rd = word_rd[{lane, 3'b000} +: 8];
    half_rd = lane[1] ? word_rd[31:16] : word_rd[15:0];
    case (op_f3)
      3'b000:  load_data = {{24{byte_rd[7]}}, byte_rd};
      3'b001:  load_data = {{16{half_rd[15]}}, half_rd};
      3'b010:  load_data = word_rd;
      3'b100:  load_data = {24'd0, byte_rd};
      3'b101:  load_data = {16'd0, half_rd};
      default: load_data = '0;
    endcase
    case (op_f3[1:0])
      2'b00:   begin be = 4'b0001 << lane;                   wd_sh = {4{op_wdata[7:0]}};  end
      2'b01:   begin be = lane[1] ? 4'b1100 : 4'b0011;       wd_sh = {2{op_wdata[15:0]}}; end
      2'b10:   begin be = 4'b1111;                           wd_sh = op_wdata;            end
      default: begin be = 4'b0000;                           wd_sh = '0;                  end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        wr_d    = req_write;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (LATENCY == 0) begin
          state_d = RESP;
        end else begin
          cnt_d   = 3'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 3'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 3'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == RESP && state_q != RESP) begin
      commit  = 1'b1;
      err_d   = op_err;
      rdata_d = (op_err || op_wr) ? '0 : load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; reset only blocks a commit.
  always_ff @(posedge clk) begin
    if (commit && rst_n && op_wr && !op_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wd_sh[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu at LATENCY 0, 1 and 3.
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic        rsp_err   [3];
  logic [31:0] rsp_rdata [3];
  logic        prev_v    [3];

  typedef struct { int k; logic err; logic [31:0] rd; int due; } exp_t;
  exp_t sbq[$];

  int nvec = 0;
  int nerr = 0;
  int ncyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    data_memory_lsu #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid[k]) begin
        check("pulse_width", 32'(prev_v[k]), 0);
        check("ready_in_resp", 32'(req_ready[k]), 0);
        if (sbq.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid[k]), 0);
        end else begin
          e = sbq.pop_front();
          check("rsp_inst", k, e.k);
          check("rsp_rdata", rsp_rdata[k], e.rd);
          check("rsp_err", 32'(rsp_err[k]), 32'(e.err));
          check("rsp_cycle", ncyc, e.due);
        end
      end
      prev_v[k] = rsp_valid[k];
    end
  end

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      check("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic drive(bit wr, bit [2:0] f3, bit [31:0] a, bit [31:0] wd);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic issue(int k, bit wr, bit [2:0] f3, bit [31:0] a, bit [31:0] wd,
                       bit e_err, bit [31:0] e_rd);
    int n = 0;
    @(posedge clk); #1;
    drive(wr, f3, a, wd);
    while (!req_ready[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[k]) begin
      check("ready_timeout", 32'(req_ready[k]), 1);
    end else begin
      sbq.push_back('{k, e_err, e_rd, ncyc + 2 + lat_of(k)});
      req_valid[k] = 1'b1;
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      check("ready_after_accept", 32'(req_ready[k]), 0);
      drain();
    end
  endtask

  task automatic sweep(int k);
    int L    = lat_of(k);
    int acc  = 0;
    int last = -1;
    @(posedge clk); #1;
    drive(1'b1, 3'b010, 32'h10, 32'h5A5A0000 + 32'(k));
    req_valid[k] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bit rb;
      rb = req_ready[k];
      if (rb) begin
        sbq.push_back('{k, 1'b0, 32'h0, ncyc + 2 + L});
        if (last >= 0) check("accept_spacing", i - last, L + 2);
        last = i;
        acc++;
      end
      @(posedge clk); #1;
      if (rb) check("ready_low_after_accept", 32'(req_ready[k]), 0);
    end
    req_valid[k] = 1'b0;
    check("accept_count", acc, (10 + L + 1) / (L + 2));
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; prev_v[k] = 1'b0;
    end
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid[1]), 0);
    check("rst_rsp_rdata", rsp_rdata[1], 0);
    check("rst_rsp_err", 32'(rsp_err[1]), 0);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("ready_after_reset", 32'(req_ready[k]), 1);

    // basic word, byte and halfword traffic at LATENCY=1
    issue(1, 1, 3'b010, 32'h0,   32'hAABBCCDD, 0, 32'h0);
    issue(1, 0, 3'b010, 32'h0,   32'h0,        0, 32'hAABBCCDD);
    issue(1, 1, 3'b010, 32'h4,   32'h11223344, 0, 32'h0);
    issue(1, 1, 3'b000, 32'h5,   32'h000000F0, 0, 32'h0);
    issue(1, 0, 3'b010, 32'h4,   32'h0,        0, 32'h1122F044);
    issue(1, 0, 3'b000, 32'h5,   32'h0,        0, 32'hFFFFFFF0);
    issue(1, 0, 3'b100, 32'h5,   32'h0,        0, 32'h000000F0);
    issue(1, 0, 3'b000, 32'h4,   32'h0,        0, 32'h00000044);
    issue(1, 1, 3'b001, 32'h6,   32'h12348001, 0, 32'h0);
    issue(1, 0, 3'b001, 32'h6,   32'h0,        0, 32'hFFFF8001);
    issue(1, 0, 3'b101, 32'h6,   32'h0,        0, 32'h00008001);
    issue(1, 0, 3'b001, 32'h4,   32'h0,        0, 32'hFFFFF044);
    issue(1, 0, 3'b010, 32'h4,   32'h0,        0, 32'h8001F044);
    issue(1, 1, 3'b010, 32'h3FC, 32'h0BADF00D, 0, 32'h0);
    issue(1, 0, 3'b010, 32'h3FC, 32'h0,        0, 32'h0BADF00D);

    // error cases leave storage alone
    issue(1, 0, 3'b010, 32'h2,   32'h0,        1, 32'h0);
    issue(1, 1, 3'b001, 32'h3,   32'hFFFFFFFF, 1, 32'h0);
    issue(1, 0, 3'b101, 32'h1,   32'h0,        1, 32'h0);
    issue(1, 1, 3'b010, 32'h400, 32'h12345678, 1, 32'h0);
    issue(1, 0, 3'b011, 32'h0,   32'h0,        1, 32'h0);
    issue(1, 0, 3'b110, 32'h0,   32'h0,        1, 32'h0);
    issue(1, 1, 3'b100, 32'h0,   32'h0000FFFF, 1, 32'h0);
    issue(1, 1, 3'b010, 32'h1,   32'h0,        1, 32'h0);
    issue(1, 0, 3'b010, 32'h0,   32'h0,        0, 32'hAABBCCDD);

    for (int k = 0; k < 3; k++) sweep(k);

    // reset during a pending LATENCY=3 store
    issue(2, 1, 3'b010, 32'h8, 32'h12345678, 0, 32'h0);
    issue(2, 0, 3'b010, 32'h8, 32'h0,        0, 32'h12345678);
    @(posedge clk); #1;
    drive(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid[2]), 0);
    check("async_rst_rdata", rsp_rdata[2], 0);
    check("async_rst_ready", 32'(req_ready[2]), 1);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    @(posedge clk); #1;
    check("ready_after_mid_reset", 32'(req_ready[2]), 1);
    repeat (6) @(posedge clk);
    issue(2, 0, 3'b010, 32'h8, 32'h0, 0, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
